// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared state encoding and PC-select codes for the PC sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        FETCH    = 2'd1,
        EXEC     = 2'd2,
        REDIRECT = 2'd3
    } pc_seq_state_t;

    // Select codes for the PC register's next-PC mux
    localparam logic [1:0] PCSRC_INC    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Multi-cycle fetch/execute control FSM driving the PC register,
//               with post-redirect flush bubble and retired-instruction count.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ready,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             jump,
    output logic [1:0]       PCsrc,
    output logic             pc_en,
    output logic             imem_req,
    output logic             instr_valid,
    output logic             flush,
    output logic [WIDTH-1:0] retired
);

    localparam int             HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    pc_seq_state_t    r_state;
    pc_seq_state_t    w_next_state;
    logic [HCW-1:0]   r_hold_cnt;
    logic [WIDTH-1:0] r_retired;
    logic             w_retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HOLD;
            r_hold_cnt <= '0;
            r_retired  <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == HOLD && r_hold_cnt != HOLD_LAST)
                r_hold_cnt <= r_hold_cnt + HCW'(1);
            else
                r_hold_cnt <= '0;
            if (w_retire)
                r_retired <= r_retired + WIDTH'(1);
        end
    end

    // PCsrc and pc_en follow the EXEC inputs combinationally so the PC
    // register loads on the same edge the instruction retires.
    always_comb begin
        w_next_state = r_state;
        PCsrc        = PCSRC_INC;
        pc_en        = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            HOLD: begin
                if (r_hold_cnt == HOLD_LAST)
                    w_next_state = FETCH;
            end
            FETCH: begin
                if (imem_ready)
                    w_next_state = EXEC;
            end
            EXEC: begin
                if (!stall) begin
                    pc_en    = 1'b1;
                    w_retire = 1'b1;
                    if (jump)
                        PCsrc = PCSRC_JUMP;
                    else if (branch_taken)
                        PCsrc = PCSRC_BRANCH;
                    w_next_state = (jump || branch_taken) ? REDIRECT : FETCH;
                end
            end
            REDIRECT: begin
                w_next_state = FETCH;
            end
            default: begin
                w_next_state = HOLD;
            end
        endcase
    end

    assign imem_req    = (r_state == FETCH);
    assign instr_valid = (r_state == EXEC);
    assign flush       = (r_state == REDIRECT);
    assign retired     = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed + randomized self-checking bench for pc_sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam int HOLD_CYCLES = 2;
    localparam int P_HOLD = 0, P_FETCH = 1, P_EXEC = 2, P_REDIR = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, imem_ready = 1'b0, stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;

    logic [1:0]  PCsrc, PCsrc_n;
    logic        pc_en, imem_req, instr_valid, flush;
    logic        pc_en_n, imem_req_n, instr_valid_n, flush_n;
    logic [31:0] retired;
    logic [3:0]  retired_n;

    pc_sequencer #(.WIDTH(32), .HOLD_CYCLES(HOLD_CYCLES)) u_dut (
        .clk(clk), .rst(rst), .imem_ready(imem_ready), .stall(stall),
        .branch_taken(branch_taken), .jump(jump), .PCsrc(PCsrc), .pc_en(pc_en),
        .imem_req(imem_req), .instr_valid(instr_valid), .flush(flush), .retired(retired)
    );

    pc_sequencer #(.WIDTH(4), .HOLD_CYCLES(HOLD_CYCLES)) u_dut_narrow (
        .clk(clk), .rst(rst), .imem_ready(imem_ready), .stall(stall),
        .branch_taken(branch_taken), .jump(jump), .PCsrc(PCsrc_n), .pc_en(pc_en_n),
        .imem_req(imem_req_n), .instr_valid(instr_valid_n), .flush(flush_n), .retired(retired_n)
    );

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: phase, hold cycles left, retirements since reset
    bit          m_known = 1'b0;
    int          m_phase = P_HOLD;
    int          m_hold_left = 0;
    int unsigned m_ret = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic rdy, input logic st,
                        input logic br, input logic jp);
        logic [1:0] e_src;
        logic       e_pc, e_req, e_val, e_fl;
        logic [3:0] e_ret_n;
        @(negedge clk);
        rst = r; imem_ready = rdy; stall = st; branch_taken = br; jump = jp;
        #1;
        if (m_known) begin
            e_src = 2'b00; e_pc = 1'b0; e_req = 1'b0; e_val = 1'b0; e_fl = 1'b0;
            case (m_phase)
                P_FETCH: e_req = 1'b1;
                P_EXEC: begin
                    e_val = 1'b1;
                    if (!st) begin
                        e_pc  = 1'b1;
                        e_src = jp ? 2'b10 : (br ? 2'b01 : 2'b00);
                    end
                end
                P_REDIR: e_fl = 1'b1;
                default: ;
            endcase
            e_ret_n = m_ret[3:0];
            chk("PCsrc", {30'd0, PCsrc}, {30'd0, e_src});
            chk("pc_en", {31'd0, pc_en}, {31'd0, e_pc});
            chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, e_val});
            chk("flush", {31'd0, flush}, {31'd0, e_fl});
            chk("retired", retired, m_ret);
            chk("retired_w4", {28'd0, retired_n}, {28'd0, e_ret_n});
            chk("PCsrc_w4", {30'd0, PCsrc_n}, {30'd0, e_src});
        end
        @(posedge clk);
        if (r) begin
            m_known = 1'b1; m_phase = P_HOLD; m_hold_left = HOLD_CYCLES; m_ret = 0;
        end else if (m_known) begin
            case (m_phase)
                P_HOLD: begin
                    m_hold_left--;
                    if (m_hold_left == 0) m_phase = P_FETCH;
                end
                P_FETCH: if (rdy) m_phase = P_EXEC;
                P_EXEC: if (!st) begin
                    m_ret++;
                    m_phase = (jp || br) ? P_REDIR : P_FETCH;
                end
                default: m_phase = P_FETCH;
            endcase
        end
    endtask

    initial begin
        // Reset for three cycles, then hold window and first fetch
        repeat (3) step(1, 0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0);
        #2 chk("first_req", {31'd0, imem_req}, 32'd1);

        // Straight-line flow: ten instructions over twenty cycles
        repeat (20) step(0, 1, 0, 0, 0);
        #2 chk("straight_retired", retired, 32'd10);

        // Memory wait: three not-ready cycles in FETCH
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        // EXEC with a two-cycle stall, branch request ignored while stalled
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        // Taken branch, then jump+branch together
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        #2 chk("branch_redirect_to_fetch", {31'd0, imem_req}, 32'd1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        #2 chk("jump_single_flush", {31'd0, flush}, 32'd0);

        // Reset while waiting in FETCH
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        #2 chk("midreset_retired", retired, 32'd0);

        // Wrap on the 4-bit instance: seventeen straight-line retirements
        begin
            int budget = 100;
            while (m_ret < 17 && budget > 0) begin
                step(0, 1, 0, 0, 0);
                budget--;
            end
            chk("wrap_budget", {31'd0, (m_ret >= 17)}, 32'd1);
            #2 chk("wrap_value", {28'd0, retired_n}, 32'd1);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
